instr_receive: RTL
==================

Name: instr_receive

Overview:
- Consumer stage directly downstream of the instruction transmitter.
- On a start request, it drives the transmitter's sync request and captures the returned instruction stream into a local instruction buffer.
- It checks the word count against the last-word flag and reports done or error.
- It provides a registered read port so the MIPS fetch stage can read the loaded program.

Parameters:
- IWIDTH, 32, instruction word width; must match the transmitter.
- DEPTH, 16, number of words per load; must equal the transmitter's DEPTH.
- AWIDTH, 4, read-address width; must satisfy 2^AWIDTH >= DEPTH.
- TIMEOUT, 16, maximum cycles in LOAD without an ack before an error is raised.

Ports:
- r_clk  in  1  clock; all logic on the rising edge.
- r_rst  in  1  reset; synchronous, active-low.
- r_i_start  in  1  one-cycle pulse that begins a load.
- r_i_instr  in  IWIDTH  instruction word from the transmitter.
- r_i_ack  in  1  transmitter word-valid strobe.
- r_i_last  in  1  transmitter last-word flag; qualified by r_i_ack.
- r_o_syn  out  1  word request to the transmitter.
- r_o_busy  out  1  high while in LOAD.
- r_o_done  out  1  load completed correctly; sticky until the next start or reset.
- r_o_err  out  1  load failed; sticky until the next start or reset.
- r_o_count  out  AWIDTH+1  number of words written in the current or last load.
- r_i_raddr  in  AWIDTH  read address from fetch.
- r_o_rdata  out  IWIDTH  registered read data.

Behaviour:
- Reset (r_rst=0 at a rising edge):
  - state=IDLE; issued=0, recv=0, timer=0.
  - r_o_done=0, r_o_err=0, r_o_count=0, r_o_rdata=0.
  - r_o_syn=0 and r_o_busy=0 (both decoded from state).
  - Buffer contents are not cleared.
- States: IDLE, LOAD, DONE, ERR.
  - r_o_busy = (state==LOAD).
  - r_o_syn = (state==LOAD) && (issued < DEPTH). Combinational, so exactly DEPTH requests are issued per load. This leaves the transmitter's word counter at 0 for the next load.
- IDLE/DONE/ERR:
  - r_i_start=1 -> LOAD next cycle.
  - Same edge clears issued, recv, timer, r_o_count, r_o_done, r_o_err.
  - r_i_ack in these states is ignored; no write occurs.
- LOAD:
  - Each cycle with r_o_syn=1: issued++.
  - r_i_start is ignored in LOAD.
  - Each cycle with r_i_ack=1: mem[recv] <= r_i_instr; recv++; r_o_count <= recv+1; timer <= 0.
  - Otherwise timer++.
  - ack && last && recv==DEPTH-1 -> DONE (word written); r_o_done <= 1.
  - ack && last && recv<DEPTH-1 -> ERR (early last; word written).
  - ack && !last && recv==DEPTH-1 -> ERR (missing last; word written).
  - timer reaches TIMEOUT-1 with no ack -> ERR.
  - Entering ERR sets r_o_err <= 1. Done and err are never both 1.
- Transmitter latency: ack arrives one cycle after the syn it answers. With an uninterrupted stream, DEPTH words arrive on DEPTH consecutive cycles starting 1 cycle after LOAD entry. Total load time is DEPTH+1 cycles from the start edge to the done edge.
- Read port:
  - r_o_rdata <= (r_i_raddr < DEPTH) ? mem[r_i_raddr] : 0 every cycle; 1-cycle latency.
  - Active in all states.
  - Reading an address on the same edge it is written returns the old contents.
- Reset mid-LOAD: returns to IDLE immediately; partially written words remain in mem; done/err are cleared.
- Widths: issued, recv and r_o_count are AWIDTH+1 bits, so DEPTH=2^AWIDTH does not wrap.

Test Plan:
- Normal load, DEPTH=4, transmitter words 0x11,0x22,0x33,0x44 with last on the 4th:
  - start -> r_o_syn high for exactly 4 cycles.
  - r_o_done=1 on cycle 5; r_o_count=4; r_o_err=0.
  - Reads of addresses 0..3 return 0x11..0x44 one cycle after each address.
- Early last, DEPTH=4, last asserted with the 2nd ack -> ERR; r_o_err=1, r_o_count=2, r_o_done=0.
- Missing last, DEPTH=4, 4 acks with last=0 -> r_o_err=1 after the 4th ack; r_o_count=4.
- Timeout, TIMEOUT=16: start with the transmitter held silent (ack=0) -> r_o_err=1 exactly 16 cycles after LOAD entry; r_o_syn drops once issued=4.
- Reset mid-load:
  - Sequence: assert r_rst=0 after 2 acks, release, start again.
  - Required: all outputs 0 after reset.
  - Second load completes with done=1 and count=4; the transmitter restarts at word 0 on the second load.
- Reload and stray acks: ack pulses in DONE are not written (mem unchanged); start in LOAD is ignored; start in DONE clears done and reloads correctly.

Source files
------------

// File: rtl/instr_receive_if.sv
// Bus between the instruction transmitter/fetch side and instr_receive.
// The slave modport is the receiver's view; master is the driving side.
interface instr_receive_if #(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned AWIDTH = 4
);
   logic              r_i_start;
   logic [IWIDTH-1:0] r_i_instr;
   logic              r_i_ack;
   logic              r_i_last;
   logic              r_o_syn;
   logic              r_o_busy;
   logic              r_o_done;
   logic              r_o_err;
   logic [AWIDTH:0]   r_o_count;
   logic [AWIDTH-1:0] r_i_raddr;
   logic [IWIDTH-1:0] r_o_rdata;

   modport master (
      output r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_raddr,
      input  r_o_syn, r_o_busy, r_o_done, r_o_err, r_o_count, r_o_rdata
   );

   modport slave (
      input  r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_raddr,
      output r_o_syn, r_o_busy, r_o_done, r_o_err, r_o_count, r_o_rdata
   );
endinterface

// File: rtl/instr_receive.sv
// Requests DEPTH words from the instruction transmitter, stores them in a local buffer,
// flags done/error from the last-word framing, and serves a registered read port.
module instr_receive #(
  parameter int unsigned IWIDTH  = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input logic              r_clk,
  input logic              r_rst,
  instr_receive_if.slave   bus
);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [AWIDTH:0] DepthW = (AWIDTH + 1)'(DEPTH);
   localparam logic [AWIDTH:0] LastW  = (AWIDTH + 1)'(DEPTH - 1);
   localparam logic [TW-1:0]   TimeLast = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

   state_e            state_q, state_d;
   logic [AWIDTH:0]   issued_q, issued_d;
   logic [AWIDTH:0]   recv_q, recv_d;
   logic [AWIDTH:0]   count_q, count_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              syn;
   logic              we;
   logic [IWIDTH-1:0] rdata_q;
   logic [IWIDTH-1:0] mem [DEPTH];

   // Combinational request so exactly DEPTH syns go out per load.
   assign syn = (state_q == StLoad) && (issued_q < DepthW);

   always_comb begin
      state_d  = state_q;
      issued_d = issued_q;
      recv_d   = recv_q;
      count_d  = count_q;
      timer_d  = timer_q;
      done_d   = done_q;
      err_d    = err_q;
      we       = 1'b0;
      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (bus.r_i_start) begin
               state_d  = StLoad;
               issued_d = '0;
               recv_d   = '0;
               count_d  = '0;
               timer_d  = '0;
               done_d   = 1'b0;
               err_d    = 1'b0;
            end
         end
         StLoad: begin
            if (syn) issued_d = issued_q + 1'b1;
            if (bus.r_i_ack) begin
               we      = 1'b1;
               recv_d  = recv_q + 1'b1;
               count_d = recv_q + 1'b1;
               timer_d = '0;
               if (recv_q == LastW) begin
                  if (bus.r_i_last) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StErr;
                     err_d   = 1'b1;
                  end
               end else if (bus.r_i_last) begin
                  state_d = StErr;
                  err_d   = 1'b1;
               end
            end else if (timer_q == TimeLast) begin
               state_d = StErr;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         state_q  <= StIdle;
         issued_q <= '0;
         recv_q   <= '0;
         count_q  <= '0;
         timer_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         recv_q   <= recv_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdata_q  <= ({1'b0, bus.r_i_raddr} < DepthW) ? mem[bus.r_i_raddr] : '0;
      end
   end

   // Buffer is deliberately left out of reset so a partial load survives it.
   always_ff @(posedge r_clk) begin
      if (r_rst && we) mem[recv_q[AWIDTH-1:0]] <= bus.r_i_instr;
   end

   assign bus.r_o_syn   = syn;
   assign bus.r_o_busy  = (state_q == StLoad);
   assign bus.r_o_done  = done_q;
   assign bus.r_o_err   = err_q;
   assign bus.r_o_count = count_q;
   assign bus.r_o_rdata = rdata_q;
endmodule
